fp_acc_quant: RTL and testbench



---
 rtl/fp_quant_pkg.sv | 18 +
 rtl/fp_quantizer.sv | 54 +++++
 rtl/fp_acc_quant.sv | 99 +++++++++
 tb/tb_fp_acc_quant.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_quant_pkg.sv
// Shared definitions for the fixed-point accumulate/requantise blocks:
// quantiser mode encodings and an elaboration-time ceil(log2()) helper.
package fp_quant_pkg;

    localparam logic [1:0] QM_TRUNC_WRAP = 2'd0;
    localparam logic [1:0] QM_TRUNC_SAT  = 2'd1;
    localparam logic [1:0] QM_ROUND_SAT  = 2'd2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_quantizer.sv
// Combinational requantiser S(NB_I,NBF_I) -> S(NB_OUT,NBF_OUT) with
// truncate/wrap, truncate/saturate and round-half-up/saturate modes.
module fp_quantizer
    import fp_quant_pkg::*;
#(
    parameter int NB_I    = 19,
    parameter int NBF_I   = 14,
    parameter int NB_OUT  = 11,
    parameter int NBF_OUT = 10
) (
    input  logic [NB_I-1:0]   i_data,
    input  logic [1:0]        i_mode,
    output logic [NB_OUT-1:0] o_data,
    output logic              o_ovf
);

    localparam int D    = NBF_I - NBF_OUT;
    localparam int NB_W = NB_I + 1 - D;
    // Half an output LSB in input units; collapses to zero when D == 0.
    localparam logic [NB_I:0] RND = ({{NB_I{1'b0}}, 1'b1} << D) >> 1;

    logic            wrap;
    logic            round;
    logic [NB_W-1:0] fl;
    logic            fits;

    always_comb begin
        wrap  = 1'b0;
        round = 1'b0;
        case (i_mode)
            QM_TRUNC_WRAP: wrap  = 1'b1;
            QM_TRUNC_SAT:  round = 1'b0;
            default:       round = 1'b1;
        endcase
    end

    // One guard bit keeps the rounding add from overflowing before the floor.
    assign fl = NB_W'(({i_data[NB_I-1], i_data} + (round ? RND : '0)) >> D);

    // In range when every bit from the output sign upwards agrees.
    assign fits = (&fl[NB_W-1:NB_OUT-1]) | ~(|fl[NB_W-1:NB_OUT-1]);

    always_comb begin
        o_ovf = ~fits;
        if (wrap || fits) begin
            o_data = fl[NB_OUT-1:0];
        end else if (fl[NB_W-1]) begin
            o_data = {1'b1, {(NB_OUT-1){1'b0}}};
        end else begin
            o_data = {1'b0, {(NB_OUT-1){1'b1}}};
        end
    end

endmodule

// File: rtl/fp_acc_quant.sv
// Integrate-and-dump accumulator: sums ACC_LEN valid samples at full
// resolution, then requantises the dump one cycle later with an overflow count.
module fp_acc_quant
    import fp_quant_pkg::*;
#(
    parameter  int NB_IN   = 16,
    parameter  int NBF_IN  = 14,
    parameter  int NB_OUT  = 11,
    parameter  int NBF_OUT = 10,
    parameter  int ACC_LEN = 8,
    parameter  int NB_CNT  = 8,
    localparam int NB_ACC  = NB_IN + clog2(ACC_LEN)
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_valid,
    input  logic [NB_IN-1:0]  i_data,
    input  logic [1:0]        i_mode,
    input  logic              i_clear,
    output logic              o_valid,
    output logic [NB_ACC-1:0] o_acc_fr,
    output logic [NB_OUT-1:0] o_data,
    output logic              o_ovf,
    output logic [NB_CNT-1:0] o_ovf_count
);

    localparam int               CNT_W = clog2(ACC_LEN);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(ACC_LEN - 1);

    logic [CNT_W-1:0]  cnt;
    logic [NB_ACC-1:0] acc;
    logic [NB_ACC-1:0] smp_ext;
    logic              s1_dump;
    logic [1:0]        s1_mode;
    logic [NB_OUT-1:0] q_data;
    logic              q_ovf;

    assign smp_ext = {{(NB_ACC-NB_IN){i_data[NB_IN-1]}}, i_data};

    // acc doubles as the stage-1 sum register: it is only overwritten by the
    // next frame's first sample, which lands no earlier than stage 2 reads it.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt     <= '0;
            acc     <= '0;
            s1_dump <= 1'b0;
            s1_mode <= QM_TRUNC_WRAP;
        end else begin
            s1_dump <= 1'b0;
            if (i_clear) begin
                cnt <= '0;
            end else if (i_valid) begin
                acc <= (cnt == '0) ? smp_ext : acc + smp_ext;
                if (cnt == LAST) begin
                    cnt     <= '0;
                    s1_dump <= 1'b1;
                    s1_mode <= i_mode;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    fp_quantizer #(
        .NB_I    (NB_ACC),
        .NBF_I   (NBF_IN),
        .NB_OUT  (NB_OUT),
        .NBF_OUT (NBF_OUT)
    ) u_quant (
        .i_data (acc),
        .i_mode (s1_mode),
        .o_data (q_data),
        .o_ovf  (q_ovf)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_valid     <= 1'b0;
            o_acc_fr    <= '0;
            o_data      <= '0;
            o_ovf       <= 1'b0;
            o_ovf_count <= '0;
        end else begin
            o_valid <= s1_dump;
            if (s1_dump) begin
                o_acc_fr <= acc;
                o_data   <= q_data;
                o_ovf    <= q_ovf;
            end
            if (i_clear) begin
                o_ovf_count <= '0;
            end else if (s1_dump && q_ovf && !(&o_ovf_count)) begin
                o_ovf_count <= o_ovf_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp_acc_quant.sv
// Self-checking bench for fp_acc_quant: directed cases plus random frames
// against an arithmetic reference; a second instance uses a 2-bit counter.
module tb_fp_acc_quant;
    import fp_quant_pkg::*;

    localparam int ACC_LEN = 8;
    localparam int DQ      = 4;
    localparam longint OMAX = 1023;
    localparam longint OMIN = -1024;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic        i_clear;
    logic [15:0] i_data;
    logic [1:0]  i_mode;

    logic        o_valid, o_ovf;
    logic [18:0] o_acc_fr;
    logic [10:0] o_data;
    logic [7:0]  o_ovf_count;

    logic        o2_valid, o2_ovf;
    logic [18:0] o2_acc_fr;
    logic [10:0] o2_data;
    logic [1:0]  o2_ovf_count;

    int n_pass  = 0;
    int n_total = 0;
    int vcount  = 0;
    int exp_c8  = 0;
    int exp_c2  = 0;
    int v0;
    logic [15:0] frame_s [ACC_LEN];

    fp_acc_quant u_dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_mode      (i_mode),
        .i_clear     (i_clear),
        .o_valid     (o_valid),
        .o_acc_fr    (o_acc_fr),
        .o_data      (o_data),
        .o_ovf       (o_ovf),
        .o_ovf_count (o_ovf_count)
    );

    fp_acc_quant #(.NB_CNT(2)) u_dut2 (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_mode      (i_mode),
        .i_clear     (i_clear),
        .o_valid     (o2_valid),
        .o_acc_fr    (o2_acc_fr),
        .o_data      (o2_data),
        .o_ovf       (o2_ovf),
        .o_ovf_count (o2_ovf_count)
    );

    always #5 i_clock = ~i_clock;

    always @(negedge i_clock) begin
        if (o_valid === 1'b1) vcount++;
    end

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < ACC_LEN; i++) frame_s[i] = v;
    endtask

    // Reference: value-domain floor / round-half-up, then range test and clamp.
    function automatic void model_q(input longint sum, input logic [1:0] mode,
                                    output longint d, output logic ovf);
        longint q;
        if (mode >= 2) q = (sum + (longint'(1) << (DQ - 1))) >>> DQ;
        else           q = sum >>> DQ;
        ovf = (q > OMAX) || (q < OMIN);
        if (mode == 2'd0 || !ovf) d = q & 64'h7FF;
        else if (q < 0)           d = 64'h400;
        else                      d = 64'h3FF;
    endfunction

    task automatic run_frame(input logic [1:0] mode, input int gap_pct);
        longint sum;
        longint d;
        logic   ovf;
        int     vstart;
        int     lat;
        sum    = 0;
        vstart = vcount;
        for (int i = 0; i < ACC_LEN; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                i_valid = 1'b0;
                i_data  = 16'($urandom);
                step();
            end
            i_valid = 1'b1;
            i_data  = frame_s[i];
            i_mode  = mode;
            sum += longint'($signed(frame_s[i]));
            step();
        end
        i_valid = 1'b0;
        i_mode  = 2'($urandom);
        lat = 0;
        while (o_valid !== 1'b1 && lat < 4) begin
            step();
            lat++;
        end
        model_q(sum, mode, d, ovf);
        if (ovf) begin
            if (exp_c8 < 255) exp_c8++;
            if (exp_c2 < 3)   exp_c2++;
        end
        chk("dump_valid", 32'(o_valid), 1);
        chk("dump_latency", lat, 1);
        chk("acc_fr", 32'(o_acc_fr), 32'(sum & 64'h7FFFF));
        chk("data", 32'(o_data), 32'(d));
        chk("ovf", 32'(o_ovf), 32'(ovf));
        chk("ovf_count", 32'(o_ovf_count), exp_c8);
        chk("ovf_count_nb2", 32'(o2_ovf_count), exp_c2);
        step();
        chk("valid_strobe_end", 32'(o_valid), 0);
        chk("valid_pulses", vcount - vstart, 1);
    endtask

    initial begin
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_clear = 1'b0;
        i_data  = '0;
        i_mode  = QM_TRUNC_WRAP;
        step();
        step();
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_acc_fr", 32'(o_acc_fr), 0);
        chk("rst_data", 32'(o_data), 0);
        chk("rst_ovf", 32'(o_ovf), 0);
        chk("rst_count", 32'(o_ovf_count), 0);
        i_reset = 1'b0;
        step();

        // +1.0 does not fit S(11,10)
        fill(16'h0800);
        run_frame(QM_TRUNC_WRAP, 0);
        chk("p1_m0_acc", 32'(o_acc_fr), 32'h04000);
        chk("p1_m0_data", 32'(o_data), 32'h400);
        chk("p1_m0_ovf", 32'(o_ovf), 1);
        run_frame(QM_TRUNC_SAT, 0);
        chk("p1_m1_data", 32'(o_data), 32'h3FF);
        run_frame(QM_ROUND_SAT, 0);
        chk("p1_m2_data", 32'(o_data), 32'h3FF);
        chk("p1_count", 32'(o_ovf_count), 3);

        fill(16'h0400);
        for (int m = 0; m < 3; m++) begin
            run_frame(2'(m), 20);
            chk("inrange_data", 32'(o_data), 32'h200);
            chk("inrange_ovf", 32'(o_ovf), 0);
            chk("inrange_count", 32'(o_ovf_count), 3);
        end

        fill(16'h0000);
        frame_s[0] = 16'h0008;
        run_frame(QM_TRUNC_SAT, 0);
        chk("rnd_pos_m1", 32'(o_data), 32'h000);
        run_frame(QM_ROUND_SAT, 0);
        chk("rnd_pos_m2", 32'(o_data), 32'h001);
        frame_s[0] = 16'hFFF8;
        run_frame(QM_TRUNC_SAT, 0);
        chk("rnd_neg_m1", 32'(o_data), 32'h7FF);
        run_frame(QM_ROUND_SAT, 0);
        chk("rnd_neg_m2", 32'(o_data), 32'h000);

        fill(16'h8000);
        run_frame(QM_TRUNC_WRAP, 0);
        chk("nfs_m0_acc", 32'(o_acc_fr), 32'h40000);
        chk("nfs_m0_data", 32'(o_data), 32'h000);
        chk("nfs_count_a", 32'(o_ovf_count), 4);
        run_frame(QM_TRUNC_SAT, 0);
        chk("nfs_m1_data", 32'(o_data), 32'h400);
        chk("nfs_count_b", 32'(o_ovf_count), 5);

        // clear together with a valid discards that sample and restarts the frame
        i_valid = 1'b1;
        i_data  = 16'h0400;
        repeat (3) step();
        i_clear = 1'b1;
        i_data  = 16'h7FFF;
        step();
        i_clear = 1'b0;
        i_valid = 1'b0;
        exp_c8 = 0;
        exp_c2 = 0;
        chk("clr_count", 32'(o_ovf_count), 0);
        fill(16'h0400);
        run_frame(QM_TRUNC_SAT, 40);
        chk("clr_data", 32'(o_data), 32'h200);

        // clear on the dump-producing edge suppresses the dump
        i_valid = 1'b1;
        i_data  = 16'h0800;
        repeat (ACC_LEN - 1) step();
        i_clear = 1'b1;
        v0 = vcount;
        step();
        i_clear = 1'b0;
        i_valid = 1'b0;
        repeat (4) step();
        chk("clr_dump_suppressed", vcount - v0, 0);

        // reset mid-frame
        fill(16'h0800);
        run_frame(QM_TRUNC_SAT, 0);
        i_valid = 1'b1;
        i_data  = 16'h0800;
        repeat (4) step();
        i_reset = 1'b1;
        step();
        chk("mid_rst_valid", 32'(o_valid), 0);
        chk("mid_rst_acc_fr", 32'(o_acc_fr), 0);
        chk("mid_rst_data", 32'(o_data), 0);
        chk("mid_rst_ovf", 32'(o_ovf), 0);
        chk("mid_rst_count", 32'(o_ovf_count), 0);
        i_reset = 1'b0;
        i_valid = 1'b0;
        exp_c8 = 0;
        exp_c2 = 0;
        step();
        fill(16'h0400);
        run_frame(QM_ROUND_SAT, 30);
        chk("post_rst_data", 32'(o_data), 32'h200);

        // 2-bit counter saturates at 3
        fill(16'h0800);
        repeat (5) run_frame(QM_TRUNC_SAT, 0);
        chk("sat_count_nb2", 32'(o2_ovf_count), 3);
        chk("sat_count_nb8", 32'(o_ovf_count), 5);
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        exp_c8 = 0;
        exp_c2 = 0;
        chk("sat_clr_nb2", 32'(o2_ovf_count), 0);
        chk("sat_clr_nb8", 32'(o_ovf_count), 0);

        for (int f = 0; f < 40; f++) begin
            for (int j = 0; j < ACC_LEN; j++) begin
                if ($urandom_range(1) == 1) frame_s[j] = 16'($urandom);
                else                        frame_s[j] = 16'($urandom_range(4095) - 2048);
            end
            run_frame(2'($urandom), 25);
            if ($urandom_range(7) == 0) begin
                i_clear = 1'b1;
                step();
                i_clear = 1'b0;
                exp_c8 = 0;
                exp_c2 = 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
